multicycle_ctrl: RTL and testbench

Moore-style control state machine for the multicycle MIPS core. It sequences a shared-memory datapath (one ALU, one instruction/data memory) through fetch, decode, execute, memory and writeback steps for RTYPE, LW, SW, BEQ, ADDI and J. It stalls on a memory-ready handshake and produces the per-cycle datapath select and write-enable signals, including the gated PC enable. It sits beside the ALU decoder, which consumes `aluop`.

---
 rtl/multicycle_ctrl.sv | 151 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM sequencing the shared-memory multicycle MIPS datapath.
// Write enables are forced low while reset_n is asserted; selects keep their FETCH values.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_pcwrite;
    logic   w_branch;
    logic   w_irwrite;
    logic   w_memwrite;
    logic   w_regwrite;
    logic   w_illegal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = S_FETCH;
        iord       = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        w_regwrite = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                alusrcb   = 2'b01;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_RTYPE:      w_next = S_EXECUTE;
                    OP_LW, OP_SW:  w_next = S_MEMADR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_ADDI:       w_next = S_ADDIEXEC;
                    OP_J:          w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            // Strobe stays high across stalls so the memory sees a stable request
            S_MEMWR: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
                w_next     = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB:
                w_regwrite = 1'b1;
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default:
                w_next = S_FETCH;
        endcase
    end

    assign irwrite  = w_irwrite & reset_n;
    assign memwrite = w_memwrite & reset_n;
    assign regwrite = w_regwrite & reset_n;
    assign illegal  = w_illegal & reset_n;
    assign pcen     = (w_pcwrite | (w_branch & zero)) & reset_n;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized checks of multicycle_ctrl against a per-instruction step model.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
    logic [1:0] alusrcb, aluop, pcsrc;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    int    step = 0;
    int    c[12];
    string nm_c[12] = '{"fetch", "irwrite", "regwrite", "rw_memtoreg", "rw_regdst", "aluop10",
                        "memwrite", "memwrite_iord", "illegal", "pcen", "pcen_branch", "pcen_jump"};

    // Steps per instruction: fetch, decode, then the class-specific steps
    function automatic int nsteps(input logic [5:0] o);
        case (o)
            6'h00:   return 4;
            6'h23:   return 5;
            6'h2b:   return 4;
            6'h04:   return 3;
            6'h08:   return 4;
            6'h02:   return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [14:0] expect_out(input int s, input logic [5:0] o, input logic mr, z, rn);
        logic io, mw, ir, rd, mt, rw, sa, il, pe;
        logic [1:0] sb, ao, ps;
        {io, mw, ir, rd, mt, rw, sa, il, pe} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        if (s == 0) begin
            sb = 2'b01; ir = mr; pe = mr;
        end else if (s == 1) begin
            sb = 2'b11; il = (nsteps(o) == 2);
        end else begin
            case (o)
                6'h00: if (s == 2) begin sa = 1; ao = 2'b10; end else begin rd = 1; rw = 1; end
                6'h23: if (s == 2) begin sa = 1; sb = 2'b10; end else if (s == 3) io = 1; else begin mt = 1; rw = 1; end
                6'h2b: if (s == 2) begin sa = 1; sb = 2'b10; end else begin io = 1; mw = 1; end
                6'h04: begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
                6'h08: if (s == 2) begin sa = 1; sb = 2'b10; end else rw = 1;
                6'h02: begin ps = 2'b10; pe = 1; end
                default: ;
            endcase
        end
        if (!rn) begin ir = 0; pe = 0; mw = 0; rw = 0; il = 0; end
        return {io, mw, ir, rd, mt, rw, sa, sb, ao, ps, pe, il};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One clock cycle: drive at posedge+2, compare at negedge+1, advance model at posedge
    task automatic cyc(input logic mr, input logic z, input logic rn);
        logic [14:0] e, a;
        mem_ready = mr; zero = z; reset_n = rn;
        if (!rn) step = 0;
        @(negedge clk);
        #1;
        e = expect_out(step, op, mem_ready, zero, reset_n);
        a = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, aluop, pcsrc, pcen, illegal};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL model t=%0t step=%0d op=%h got=%b required=%b", $time, step, op, a, e);
        end
        c[0]  += int'(alusrcb == 2'b01);
        c[1]  += int'(irwrite);
        c[2]  += int'(regwrite);
        c[3]  += int'(regwrite & memtoreg);
        c[4]  += int'(regwrite & regdst);
        c[5]  += int'(aluop == 2'b10);
        c[6]  += int'(memwrite);
        c[7]  += int'(memwrite & iord);
        c[8]  += int'(illegal);
        c[9]  += int'(pcen);
        c[10] += int'(pcen && pcsrc == 2'b01);
        c[11] += int'(pcen && pcsrc == 2'b10);
        @(posedge clk);
        if (reset_n) begin
            if (!((step == 0 || (step == 3 && (op == 6'h23 || op == 6'h2b))) && !mem_ready))
                step = (step + 1) % nsteps(op);
        end
        #2;
    endtask

    task automatic clr();
        for (int i = 0; i < 12; i++) c[i] = 0;
    endtask

    // f fetch-stall cycles, m stall cycles in the memory step, n cycles in the window
    task automatic run(input logic [5:0] o, input logic z, input int f, input int m, input int n,
                       input string nm, input int e[12]);
        op = o;
        clr();
        for (int k = 0; k < n; k++)
            cyc(!(k < f || (k >= f + 3 && k < f + 3 + m)), z, 1'b1);
        for (int i = 0; i < 12; i++) chk({nm, "_", nm_c[i]}, c[i], e[i]);
    endtask

    initial begin
        @(posedge clk);
        #2;
        clr();
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0);
        chk("rst_irwrite", c[1], 0);
        chk("rst_pcen", c[9], 0);
        chk("rst_memwrite", c[6], 0);
        chk("rst_regwrite", c[2], 0);
        chk("rst_fetch_sel", c[0], 3);
        //                                   fe ir rw mt rd a10 mw mi il pc pb pj
        run(6'h00, 1'b0, 0, 0, 4,  "rtype", '{1, 1, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0});
        run(6'h23, 1'b0, 2, 3, 10, "lw",    '{3, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0});
        run(6'h2b, 1'b0, 0, 1, 5,  "sw",    '{1, 1, 0, 0, 0, 0, 2, 2, 0, 1, 0, 0});
        run(6'h04, 1'b1, 0, 0, 3,  "beq_t", '{1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0});
        run(6'h04, 1'b0, 0, 0, 3,  "beq_n", '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0});
        run(6'h02, 1'b0, 0, 0, 3,  "j",     '{1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1});
        run(6'h3f, 1'b0, 0, 0, 2,  "ill",   '{1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0});
        run(6'h08, 1'b0, 1, 0, 5,  "addi",  '{2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0});
        clr();
        cyc(1'b1, 1'b0, 1'b1);
        chk("end_in_fetch", c[0], 1);
        for (int k = 0; k < 4000; k++) begin
            if (step == 0 && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 6))
                    0: op = 6'h00;
                    1: op = 6'h23;
                    2: op = 6'h2b;
                    3: op = 6'h04;
                    4: op = 6'h08;
                    5: op = 6'h02;
                    default: op = 6'($urandom);
                endcase
            end
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 99) != 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
